// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the lab display logic.
// Glyphs are active-low with bit order [6:0] = g,f,e,d,c,b,a.
// Contents: digit/display widths, the ten digit glyphs and a blank glyph.
package seg7_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/detect_event_counter_if.sv
// Signal bundle between the sequence detector side and the event counter.
//   z         detection flag (synchronous to clock)
//   enable    count enable
//   clear     synchronous clear of count and overflow
//   count_bcd [7:4] tens, [3:0] units
//   overflow  sticky wrap flag
//   hex0/hex1 active-low seven-segment for units/tens
// master: drives z/enable/clear; slave: the counter, drives the results.
interface detect_event_counter_if;
    import seg7_pkg::*;

    logic                   z;
    logic                   enable;
    logic                   clear;
    logic [2*BCD_W-1:0]     count_bcd;
    logic                   overflow;
    logic [SEG_W-1:0]       hex0;
    logic [SEG_W-1:0]       hex1;

    modport master (
        output z, enable, clear,
        input  count_bcd, overflow, hex0, hex1
    );

    modport slave (
        input  z, enable, clear,
        output count_bcd, overflow, hex0, hex1
    );
endinterface

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
//   bcd_i [3:0]  digit 0-9
//   seg_o [6:0]  glyph, bit order g,f,e,d,c,b,a; codes above 9 show blank
module bcd_to_seven_seg
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/detect_event_counter.sv
// Two-digit BCD counter of detection events with sticky overflow and
// seven-segment outputs for the lab board.
//   clock     system clock, all state on posedge
//   resetnot  asynchronous active-low reset
//   bus       slave side of detect_event_counter_if (z/enable/clear in,
//             count_bcd/overflow/hex0/hex1 out)
// COUNT_LEVEL = 0 counts rising edges of z, 1 counts every high cycle.
// MAX_DIGIT is the per-digit carry point (9 for real BCD).
module detect_event_counter
    import seg7_pkg::*;
#(
    parameter int COUNT_LEVEL = 0,
    parameter int MAX_DIGIT   = 9
) (
    input  logic                   clock,
    input  logic                   resetnot,
    detect_event_counter_if.slave  bus
);

    localparam logic [BCD_W-1:0] MAX_D = BCD_W'(MAX_DIGIT);

    logic             z_prev_q;
    logic [BCD_W-1:0] units_q, units_d;
    logic [BCD_W-1:0] tens_q,  tens_d;
    logic             overflow_q, overflow_d;
    logic             event_w;

    // Edge mode looks at the previous sample so a long high run counts once.
    always_comb begin
        if (COUNT_LEVEL != 0) event_w = bus.z;
        else                  event_w = bus.z & ~z_prev_q;
    end

    always_comb begin
        units_d    = units_q;
        tens_d     = tens_q;
        overflow_d = overflow_q;
        // Clear wins over a coincident event, which is simply dropped.
        if (bus.clear) begin
            units_d    = '0;
            tens_d     = '0;
            overflow_d = 1'b0;
        end else if (bus.enable && event_w) begin
            if (units_q < MAX_D) begin
                units_d = units_q + 1'b1;
            end else begin
                units_d = '0;
                if (tens_q < MAX_D) begin
                    tens_d = tens_q + 1'b1;
                end else begin
                    tens_d     = '0;
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // z_prev tracks z every cycle, independent of enable/clear, so an edge
    // seen while disabled is never counted later.
    always_ff @(posedge clock or negedge resetnot) begin
        if (!resetnot) begin
            z_prev_q   <= 1'b0;
            units_q    <= '0;
            tens_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            z_prev_q   <= bus.z;
            units_q    <= units_d;
            tens_q     <= tens_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.count_bcd = {tens_q, units_q};
    assign bus.overflow  = overflow_q;

    bcd_to_seven_seg u_hex0 (
        .bcd_i (units_q),
        .seg_o (bus.hex0)
    );

    bcd_to_seven_seg u_hex1 (
        .bcd_i (tens_q),
        .seg_o (bus.hex1)
    );

endmodule

// File: tb/tb_detect_event_counter.sv
// Scoreboard bench: an edge-mode and a level-mode counter share the same
// stimulus; a decimal reference model predicts both after every clock.
module tb_detect_event_counter;

    logic clock = 1'b0;
    logic resetnot = 1'b1;
    logic z = 1'b0, en = 1'b0, clr = 1'b0;

    detect_event_counter_if bus_e ();
    detect_event_counter_if bus_l ();

    assign bus_e.z = z;  assign bus_e.enable = en;  assign bus_e.clear = clr;
    assign bus_l.z = z;  assign bus_l.enable = en;  assign bus_l.clear = clr;

    detect_event_counter #(.COUNT_LEVEL(0), .MAX_DIGIT(9)) dut_e (
        .clock(clock), .resetnot(resetnot), .bus(bus_e));
    detect_event_counter #(.COUNT_LEVEL(1), .MAX_DIGIT(9)) dut_l (
        .clock(clock), .resetnot(resetnot), .bus(bus_l));

    always #25 clock = ~clock;

    typedef struct {
        logic [7:0] bcd_e; logic ovf_e; logic [6:0] h0_e; logic [6:0] h1_e;
        logic [7:0] bcd_l; logic ovf_l; logic [6:0] h0_l; logic [6:0] h1_l;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: plain decimal counts 0..99
    int   cnt_e = 0, cnt_l = 0;
    bit   ovf_e = 0, ovf_l = 0, prev_z = 0;
    logic [6:0] glyph [10];

    initial begin
        glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;
    end

    function automatic logic [7:0] to_bcd(int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        cnt_e = 0; cnt_l = 0; ovf_e = 0; ovf_l = 0; prev_z = 0;
    endtask

    // Predict the state after the next posedge for the current inputs.
    task automatic model_step();
        exp_t e;
        bit ev_e, ev_l;
        ev_e = z && !prev_z;
        ev_l = z;
        if (clr) begin
            cnt_e = 0; ovf_e = 0; cnt_l = 0; ovf_l = 0;
        end else if (en) begin
            if (ev_e) begin if (cnt_e == 99) ovf_e = 1; cnt_e = (cnt_e + 1) % 100; end
            if (ev_l) begin if (cnt_l == 99) ovf_l = 1; cnt_l = (cnt_l + 1) % 100; end
        end
        prev_z = z;
        e.bcd_e = to_bcd(cnt_e); e.ovf_e = ovf_e;
        e.h0_e = glyph[cnt_e % 10]; e.h1_e = glyph[cnt_e / 10];
        e.bcd_l = to_bcd(cnt_l); e.ovf_l = ovf_l;
        e.h0_l = glyph[cnt_l % 10]; e.h1_l = glyph[cnt_l / 10];
        exp_q.push_back(e);
    endtask

    task automatic drive(bit zi, bit ei, bit ci);
        @(negedge clock);
        z = zi; en = ei; clr = ci;
        model_step();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_rst_bcd_e"}, bus_e.count_bcd, 8'h00);
        chk({tag, "_rst_ovf_e"}, {7'd0, bus_e.overflow}, 8'h00);
        chk({tag, "_rst_hex0_e"}, {1'b0, bus_e.hex0}, {1'b0, 7'b1000000});
        chk({tag, "_rst_hex1_e"}, {1'b0, bus_e.hex1}, {1'b0, 7'b1000000});
        chk({tag, "_rst_bcd_l"}, bus_l.count_bcd, 8'h00);
        chk({tag, "_rst_ovf_l"}, {7'd0, bus_l.overflow}, 8'h00);
    endtask

    // Monitor: one scoreboard entry is consumed after every posedge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("bcd_edge",  bus_e.count_bcd, e.bcd_e);
                chk("ovf_edge",  {7'd0, bus_e.overflow}, {7'd0, e.ovf_e});
                chk("hex0_edge", {1'b0, bus_e.hex0}, {1'b0, e.h0_e});
                chk("hex1_edge", {1'b0, bus_e.hex1}, {1'b0, e.h1_e});
                chk("bcd_lvl",   bus_l.count_bcd, e.bcd_l);
                chk("ovf_lvl",   {7'd0, bus_l.overflow}, {7'd0, e.ovf_l});
                chk("hex0_lvl",  {1'b0, bus_l.hex0}, {1'b0, e.h0_l});
                chk("hex1_lvl",  {1'b0, bus_l.hex1}, {1'b0, e.h1_l});
                $display("cyc t=%0t z=%0b en=%0b clr=%0b edge=%h/%0b lvl=%h/%0b",
                         $time, z, en, clr, bus_e.count_bcd, bus_e.overflow,
                         bus_l.count_bcd, bus_l.overflow);
            end
        end
    end

    initial begin
        // Asynchronous reset pulse with no clock edge inside it.
        #5 resetnot = 1'b0;
        #2 check_reset_outputs("init");
        #3 resetnot = 1'b1;
        model_reset();

        // Edge/level pattern: 1,1,1,0,0,1
        drive(1, 1, 0); drive(1, 1, 0); drive(1, 1, 0);
        drive(0, 1, 0); drive(0, 1, 0); drive(1, 1, 0);
        @(posedge clock); #1;
        chk("pat_edge_bcd",  bus_e.count_bcd, 8'h02);
        chk("pat_edge_hex0", {1'b0, bus_e.hex0}, {1'b0, 7'b0100100});
        chk("pat_lvl_bcd",   bus_l.count_bcd, 8'h04);
        chk("pat_lvl_hex0",  {1'b0, bus_l.hex0}, {1'b0, 7'b0011001});
        chk("pat_lvl_hex1",  {1'b0, bus_l.hex1}, {1'b0, 7'b1000000});

        // Carry and wrap in level mode.
        drive(0, 1, 1);
        for (int i = 1; i <= 105; i++) begin
            drive(1, 1, 0);
            @(posedge clock); #1;
            if (i == 9)   chk("wrap_9",   bus_l.count_bcd, 8'h09);
            if (i == 10)  chk("wrap_10",  bus_l.count_bcd, 8'h10);
            if (i == 100) begin
                chk("wrap_100",     bus_l.count_bcd, 8'h00);
                chk("wrap_100_ovf", {7'd0, bus_l.overflow}, 8'h01);
            end
            if (i == 105) begin
                chk("wrap_105",     bus_l.count_bcd, 8'h05);
                chk("wrap_105_ovf", {7'd0, bus_l.overflow}, 8'h01);
            end
        end

        // Clear priority: reach 37, then clear coincident with a rising z.
        drive(0, 1, 1);
        for (int i = 0; i < 37; i++) drive(1, 1, 0);
        drive(0, 1, 0);
        @(posedge clock); #1;
        chk("pre_clr_37", bus_l.count_bcd, 8'h37);
        drive(1, 1, 1);
        @(posedge clock); #1;
        chk("clr_bcd_l", bus_l.count_bcd, 8'h00);
        chk("clr_ovf_l", {7'd0, bus_l.overflow}, 8'h00);
        drive(1, 1, 0);
        @(posedge clock); #1;
        chk("clr_hold_e", bus_e.count_bcd, 8'h00);

        // Enable gating.
        drive(0, 1, 1);
        drive(1, 0, 0); drive(0, 0, 0); drive(1, 0, 0); drive(0, 0, 0);
        drive(1, 0, 0); drive(1, 1, 0); drive(1, 1, 0);
        @(posedge clock); #1;
        chk("gate_e", bus_e.count_bcd, 8'h00);
        chk("gate_l", bus_l.count_bcd, 8'h02);
        drive(0, 1, 0); drive(1, 1, 0);
        @(posedge clock); #1;
        chk("gate_fresh_e", bus_e.count_bcd, 8'h01);

        // Mid-count asynchronous reset; z already high afterwards is an edge.
        for (int i = 0; i < 3; i++) drive(1'(i % 2), 1, 0);
        @(negedge clock);
        resetnot = 1'b0;
        #1 check_reset_outputs("mid");
        #4 resetnot = 1'b1;
        model_reset();
        z = 1; en = 1; clr = 0;
        model_step();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 199) == 0));
        end

        // Drain the scoreboard with a bounded wait.
        begin
            int budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clock); #2;
                budget--;
            end
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
